line_event_encoder: RTL and testbench
=====================================

// Module: line_event_encoder
// PURPOSE
//  Inverse of the 2-to-4 line decoder: samples N active-low one-hot request lines, detects new assertions,
//  priority-encodes each event to a binary index and queues it in a small FIFO.
//  Drains the FIFO over a valid/ready handshake. Sits between pad-level request lines (ui_in) and the core
//  logic that consumes line indices.
// PARAMETERS
//  N_LINES      4   number of request lines (power of 2, >=2)
//  CODE_W       2   index width = $clog2(N_LINES); derived, do not override
//  FIFO_DEPTH   4   event queue entries (power of 2, >=2)
//  SYNC_STAGES  2   input synchronizer flops per line (>=2)
// PORTS
//  clk         in   1                    rising-edge clock, single clock domain
//  rst         in   1                    synchronous reset, active-high
//  en_n        in   1                    enable, active-low (same sense as decoder E); 1 = ignore new events
//  lines_n     in   N_LINES              request lines, active-low, asynchronous to clk
//  code_out    out  CODE_W               index of event at FIFO head
//  code_valid  out  1                    code_out holds a queued event
//  code_ready  in   1                    consumer accepts head when code_valid&&code_ready
//  fifo_count  out  $clog2(FIFO_DEPTH)+1 entries queued
//  multi_err   out  1                    sticky: >1 line newly asserted in one cycle
//  overflow    out  1                    sticky: event dropped, FIFO full
//  err_clr     in   1                    clears multi_err and overflow
// BEHAVIOUR
//  Reset (rst=1 at edge): code_out=0, code_valid=0, fifo_count=0, multi_err=0, overflow=0. FIFO flushed;
//   sync flops and edge-history reset to all-ones (deasserted). Reset mid-operation discards queued events.
//  Sync: lines_n -> SYNC_STAGES flops -> s_n. asserted = ~s_n. rise = asserted & ~asserted_d (asserted_d
//   = asserted delayed one cycle). asserted_d updates every cycle regardless of en_n.
//  Event: ev = (rise != 0) && !en_n. Index = lowest set bit of rise (bit 0 highest priority).
//   popcount(rise) > 1 and ev -> multi_err set; lowest index still pushed; other lines dropped.
//  Latency: line falls before edge k -> entry written at edge k+SYNC_STAGES -> code_valid=1 after that edge
//   if FIFO was empty (3 edges at default).
//  Held line produces exactly one event; release (rising lines_n) produces none; re-assert -> new event.
//  Line held low through reset -> one event after reset release (history resets deasserted).
//  en_n=1 masks events; a line asserted while masked, still held when en_n drops -> no event.
//  FIFO: show-ahead; code_out = head, valid = count!=0. Pop on code_valid&&code_ready.
//   Push+pop same cycle: both occur, count unchanged, including when full.
//   Push while full without pop: event dropped, overflow set, contents unchanged.
//   Pointers wrap modulo FIFO_DEPTH; count saturates 0..FIFO_DEPTH.
//  code_out/code_valid stable while code_valid&&!code_ready.
//  err_clr=1: flags cleared next edge unless a setting event occurs that same cycle (set wins).
//  All outputs driven from registers.
// STRUCTURE
//  Package line_enc_pkg: CODE_W computation, typedef logic [CODE_W-1:0] line_code_t,
//   function lowest_index(), function popcount().
//  Sub-module: line_enc_fifo (synchronous show-ahead FIFO, DEPTH/WIDTH params, push/pop/full/empty/count).
//  Top holds synchronizer, edge detect, encoder, error flags.
// TESTING
//  1 Reset, lines_n=4'hF, ready=1: outputs all 0 for 20 cycles; no events.
//  2 lines_n 4'hF->4'hB (line 2), ready=0: code_valid=1 after 3rd edge, code_out=2, count=1; hold line 100
//    cycles -> count stays 1.
//  3 lines_n 4'hF->4'h9 (lines 1,2 together): one entry code_out=1, multi_err=1; err_clr pulse -> 0.
//  4 ready=0, five distinct events 0,1,2,3,0: count=4, overflow=1, drain order 0,1,2,3 then code_valid=0.
//  5 FIFO full, ready=1 and new event same cycle: count stays 4, overflow=0, new code at tail.
//  6 en_n=1, assert line 3, en_n->0 while held: no event; release+re-assert line 3 -> code_out=3;
//    rst mid-queue -> count=0.

Source files
------------

// File: rtl/line_enc_pkg.sv
// Shared types and helpers for the line event encoder: code width, line index type,
// priority encoder and population count over the request vector.
package line_enc_pkg;

  localparam int N_LINES_DEF = 4;
  localparam int CODE_W      = $clog2(N_LINES_DEF);

  typedef logic [CODE_W-1:0] line_code_t;

  // Bit 0 has the highest priority, so scan from the top and let lower bits overwrite.
  function automatic line_code_t lowest_index(input logic [N_LINES_DEF-1:0] v);
    line_code_t idx;
    idx = '0;
    for (int i = N_LINES_DEF - 1; i >= 0; i--) begin
      if (v[i]) idx = line_code_t'(i);
    end
    return idx;
  endfunction

  function automatic int unsigned popcount(input logic [N_LINES_DEF-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < N_LINES_DEF; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/line_enc_fifo.sv
// Synchronous show-ahead FIFO: rd_data always presents the head entry; push and pop may
// coincide, including when full, in which case the freed head slot takes the new entry.
module line_enc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_next;
  logic             wr_ok;
  logic             rd_ok;

  // NOTE: every signal assigned in an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ok      = push && (!full || pop);
    rd_ok      = pop && !empty;
    count_next = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values,
  // independent of statement order. The storage array is reset as well: it is tiny, and
  // the head output must read zero straight out of reset rather than stale data.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_ok) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == CNT_W'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/line_event_encoder.sv
// Synchronizes active-low request lines, turns new assertions into priority-encoded
// line indices and queues them for a valid/ready consumer, with sticky error flags.
module line_event_encoder
  import line_enc_pkg::*;
#(
  parameter int N_LINES     = N_LINES_DEF,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en_n,
  input  logic [N_LINES-1:0]          lines_n,
  output logic [CODE_W-1:0]           code_out,
  output logic                        code_valid,
  input  logic                        code_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        multi_err,
  output logic                        overflow,
  input  logic                        err_clr
);

  logic [N_LINES-1:0] sync_q [SYNC_STAGES];
  logic [N_LINES-1:0] asserted;
  logic [N_LINES-1:0] asserted_d;
  logic [N_LINES-1:0] rise;
  logic               ev;
  logic               ev_multi;
  line_code_t         ev_code;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic               ovf_set;

  // Synchronizer resets to all-ones so a line held low through reset reads as a fresh
  // assertion once reset is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
    end else begin
      sync_q[0] <= lines_n;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // History tracks the lines even while disabled, so a line already held when the
  // enable arrives is not mistaken for a new event.
  always_ff @(posedge clk) begin
    if (rst) asserted_d <= '0;
    else     asserted_d <= asserted;
  end

  always_comb begin
    asserted = ~sync_q[SYNC_STAGES-1];
    rise     = asserted & ~asserted_d;
    ev       = (rise != '0) && !en_n;
    ev_code  = lowest_index(rise);
    ev_multi = ev && (popcount(rise) > 1);
    pop      = code_valid && code_ready;
    ovf_set  = ev && fifo_full && !pop;
  end

  line_enc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CODE_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (ev),
    .wr_data (ev_code),
    .pop     (pop),
    .rd_data (code_out),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign code_valid = !fifo_empty;

  // A setting event in the same cycle as err_clr wins over the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      multi_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (ev_multi)     multi_err <= 1'b1;
      else if (err_clr) multi_err <= 1'b0;
      if (ovf_set)      overflow  <= 1'b1;
      else if (err_clr) overflow  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_line_event_encoder.sv
// Directed bench for line_event_encoder: a table of input/expectation records applied in
// order, plus hand-written sequences for masking, reset-while-held and mid-queue reset.
module tb_line_event_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_n;
  logic [3:0] lines_n;
  logic [1:0] code_out;
  logic       code_valid;
  logic       code_ready;
  logic [2:0] fifo_count;
  logic       multi_err;
  logic       overflow;
  logic       err_clr;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      name;
    logic [3:0] lines_n;
    logic       en_n;
    logic       ready;
    logic       err_clr;
    int         cycles;
    logic       exp_valid;
    logic [1:0] exp_code;
    logic [2:0] exp_count;
    logic       exp_multi;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[$];

  line_event_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .en_n       (en_n),
    .lines_n    (lines_n),
    .code_out   (code_out),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .fifo_count (fifo_count),
    .multi_err  (multi_err),
    .overflow   (overflow),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [3:0] l, input logic e, input logic r,
                         input logic c, input int cyc, input logic ev, input logic [1:0] ec,
                         input logic [2:0] en, input logic em, input logic eo);
    vec_t v;
    v.name = name; v.lines_n = l; v.en_n = e; v.ready = r; v.err_clr = c; v.cycles = cyc;
    v.exp_valid = ev; v.exp_code = ec; v.exp_count = en; v.exp_multi = em; v.exp_ovf = eo;
    vecs.push_back(v);
  endtask

  task automatic run_vec(input vec_t v);
    lines_n    = v.lines_n;
    en_n       = v.en_n;
    code_ready = v.ready;
    err_clr    = v.err_clr;
    repeat (v.cycles) tick();
    check({v.name, ".valid"}, 32'(code_valid), 32'(v.exp_valid));
    if (v.exp_valid) check({v.name, ".code"}, 32'(code_out), 32'(v.exp_code));
    check({v.name, ".count"}, 32'(fifo_count), 32'(v.exp_count));
    check({v.name, ".multi"}, 32'(multi_err), 32'(v.exp_multi));
    check({v.name, ".ovf"}, 32'(overflow), 32'(v.exp_ovf));
  endtask

  task automatic hand(input string name, input logic [3:0] l, input logic e, input logic r,
                      input int cyc, input logic ev, input logic [1:0] ec, input logic [2:0] en);
    vec_t v;
    v.name = name; v.lines_n = l; v.en_n = e; v.ready = r; v.err_clr = 1'b0; v.cycles = cyc;
    v.exp_valid = ev; v.exp_code = ec; v.exp_count = en; v.exp_multi = 1'b0; v.exp_ovf = 1'b0;
    run_vec(v);
  endtask

  initial begin
    // Line 2 alone: three edges of latency, then a held line stays one event.
    add_vec("l2_lat2",    4'hB, 0, 0, 0,   2, 0, 0, 0, 0, 0);
    add_vec("l2_lat3",    4'hB, 0, 0, 0,   1, 1, 2, 1, 0, 0);
    add_vec("l2_hold",    4'hB, 0, 0, 0, 100, 1, 2, 1, 0, 0);
    add_vec("l2_release", 4'hF, 0, 1, 0,   4, 0, 0, 0, 0, 0);
    // Lines 1 and 2 together: lowest index queued, multi_err set then cleared.
    add_vec("multi",      4'h9, 0, 0, 0,   3, 1, 1, 1, 1, 0);
    add_vec("multi_clr",  4'h9, 0, 0, 1,   1, 1, 1, 1, 0, 0);
    add_vec("multi_drn",  4'hF, 0, 1, 0,   4, 0, 0, 0, 0, 0);
    // Five events 0,1,2,3,0 with no consumer: last one is dropped.
    add_vec("ovf_e0",     4'hE, 0, 0, 0,   3, 1, 0, 1, 0, 0);
    add_vec("ovf_e1",     4'hD, 0, 0, 0,   3, 1, 0, 2, 0, 0);
    add_vec("ovf_e2",     4'hB, 0, 0, 0,   3, 1, 0, 3, 0, 0);
    add_vec("ovf_e3",     4'h7, 0, 0, 0,   3, 1, 0, 4, 0, 0);
    add_vec("ovf_e0b",    4'hE, 0, 0, 0,   3, 1, 0, 4, 0, 1);
    add_vec("drain1",     4'hE, 0, 1, 0,   1, 1, 1, 3, 0, 1);
    add_vec("drain2",     4'hE, 0, 1, 0,   1, 1, 2, 2, 0, 1);
    add_vec("drain3",     4'hE, 0, 1, 0,   1, 1, 3, 1, 0, 1);
    add_vec("drain_mt",   4'hE, 0, 1, 0,   1, 0, 0, 0, 0, 1);
    add_vec("ovf_clr",    4'hE, 0, 1, 1,   1, 0, 0, 0, 0, 0);
    // Refill with 1,2,3,0, then push and pop in the same cycle while full.
    add_vec("full_e1",    4'hD, 0, 0, 0,   3, 1, 1, 1, 0, 0);
    add_vec("full_e2",    4'hB, 0, 0, 0,   3, 1, 1, 2, 0, 0);
    add_vec("full_e3",    4'h7, 0, 0, 0,   3, 1, 1, 3, 0, 0);
    add_vec("full_e0",    4'hE, 0, 0, 0,   3, 1, 1, 4, 0, 0);
    add_vec("full_pre",   4'hD, 0, 0, 0,   2, 1, 1, 4, 0, 0);
    add_vec("full_pp",    4'hD, 0, 1, 0,   1, 1, 2, 4, 0, 0);
    add_vec("full_d1",    4'hD, 0, 1, 0,   1, 1, 3, 3, 0, 0);
    add_vec("full_d2",    4'hD, 0, 1, 0,   1, 1, 0, 2, 0, 0);
    add_vec("full_d3",    4'hD, 0, 1, 0,   1, 1, 1, 1, 0, 0);
    add_vec("full_d4",    4'hD, 0, 1, 0,   1, 0, 0, 0, 0, 0);

    rst        = 1'b1;
    en_n       = 1'b0;
    lines_n    = 4'hF;
    code_ready = 1'b1;
    err_clr    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check($sformatf("reset_idle[%0d]", i),
            32'({code_out, code_valid, fifo_count, multi_err, overflow}), 32'd0);
      tick();
    end

    foreach (vecs[i]) run_vec(vecs[i]);

    // Line asserted while masked and still held when enabled: no event.
    hand("m_release", 4'hF, 0, 1, 3, 0, 0, 0);
    hand("m_masked",  4'h7, 1, 0, 4, 0, 0, 0);
    hand("m_enable",  4'h7, 0, 0, 4, 0, 0, 0);
    hand("m_free",    4'hF, 0, 0, 3, 0, 0, 0);
    hand("m_reassert",4'h7, 0, 0, 3, 1, 3, 1);
    hand("m_free2",   4'hF, 0, 0, 3, 1, 3, 1);
    hand("m_line2",   4'hB, 0, 0, 3, 1, 3, 2);

    // Reset with events queued and line 2 held low throughout.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid.count", 32'(fifo_count), 32'd0);
    check("rst_mid.valid", 32'(code_valid), 32'd0);
    check("rst_mid.code",  32'(code_out), 32'd0);
    hand("rst_held_wait", 4'hB, 0, 0, 2, 0, 0, 0);
    hand("rst_held_ev",   4'hB, 0, 0, 1, 1, 2, 1);
    hand("rst_held_once", 4'hB, 0, 0, 10, 1, 2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
